// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage core: widths, ALU opcodes, bypass bit
// positions and the per-instruction control bundle.
package core_pkg;

  localparam int XLEN = 32;
  localparam int OPW  = 4;

  localparam logic [OPW-1:0] ALU_ADD  = 4'h0;
  localparam logic [OPW-1:0] ALU_SUB  = 4'h1;
  localparam logic [OPW-1:0] ALU_AND  = 4'h2;
  localparam logic [OPW-1:0] ALU_OR   = 4'h3;
  localparam logic [OPW-1:0] ALU_XOR  = 4'h4;
  localparam logic [OPW-1:0] ALU_SLL  = 4'h5;
  localparam logic [OPW-1:0] ALU_SRL  = 4'h6;
  localparam logic [OPW-1:0] ALU_SRA  = 4'h7;
  localparam logic [OPW-1:0] ALU_SLT  = 4'h8;
  localparam logic [OPW-1:0] ALU_SLTU = 4'h9;

  // Bit positions inside each 2-bit bypass select.
  localparam int BP_RA = 1;
  localparam int BP_RB = 0;

  typedef struct packed {
    logic we;
    logic ld;
    logic st;
    logic br;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{we: 1'b0, ld: 1'b0, st: 1'b0, br: 1'b0};

endpackage

// File: rtl/operand_fwd_mux.sv
// Resolves one source operand: x0 forces zero, then EX > MEM > WB bypass,
// falling back to the register-file read value.
module operand_fwd_mux
  import core_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [4:0]   idx_i,
  input  logic [W-1:0] reg_val_i,
  input  logic         ex_sel_i,
  input  logic         mem_sel_i,
  input  logic         wb_sel_i,
  input  logic [W-1:0] ex_bus_i,
  input  logic [W-1:0] mem_bus_i,
  input  logic [W-1:0] wb_bus_i,
  output logic [W-1:0] val_o
);

  always_comb begin
    val_o = reg_val_i;
    if (idx_i == 5'd0)  val_o = '0;
    else if (ex_sel_i)  val_o = ex_bus_i;
    else if (mem_sel_i) val_o = mem_bus_i;
    else if (wb_sel_i)  val_o = wb_bus_i;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwards operands, captures control, and inserts
// bubbles on load-use stall or branch flush while honouring EX back-pressure.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN,
  parameter int OPW  = core_pkg::OPW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            D_valid,
  input  logic [XLEN-1:0] D_pc,
  input  logic [4:0]      D_ra,
  input  logic [4:0]      D_rb,
  input  logic [4:0]      D_rd,
  input  logic [XLEN-1:0] D_ra_val,
  input  logic [XLEN-1:0] D_rb_val,
  input  logic [XLEN-1:0] D_imm,
  input  logic [OPW-1:0]  D_alu_op,
  input  logic            D_we,
  input  logic            D_ld,
  input  logic            D_st,
  input  logic            D_br,
  input  logic            stall_D,
  input  logic [1:0]      EX_D_bp,
  input  logic [1:0]      MEM_D_bp,
  input  logic [1:0]      WB_D_bp,
  input  logic [XLEN-1:0] EX_alu_out,
  input  logic [XLEN-1:0] Mem_data_mem,
  input  logic [XLEN-1:0] WB_data_mem,
  input  logic            flush,
  input  logic            hold_EX,
  output logic            EX_valid,
  output logic [XLEN-1:0] EX_pc,
  output logic [XLEN-1:0] EX_a,
  output logic [XLEN-1:0] EX_b,
  output logic [XLEN-1:0] EX_imm,
  output logic [4:0]      EX_rd,
  output logic [OPW-1:0]  EX_alu_op,
  output logic            EX_we,
  output logic            EX_ld,
  output logic            EX_st,
  output logic            EX_br,
  output logic [31:0]     bubble_cnt
);

  logic [XLEN-1:0] a_fwd, b_fwd;

  operand_fwd_mux #(.W(XLEN)) u_fwd_a (
    .idx_i(D_ra), .reg_val_i(D_ra_val),
    .ex_sel_i(EX_D_bp[BP_RA]), .mem_sel_i(MEM_D_bp[BP_RA]), .wb_sel_i(WB_D_bp[BP_RA]),
    .ex_bus_i(EX_alu_out), .mem_bus_i(Mem_data_mem), .wb_bus_i(WB_data_mem),
    .val_o(a_fwd)
  );

  operand_fwd_mux #(.W(XLEN)) u_fwd_b (
    .idx_i(D_rb), .reg_val_i(D_rb_val),
    .ex_sel_i(EX_D_bp[BP_RB]), .mem_sel_i(MEM_D_bp[BP_RB]), .wb_sel_i(WB_D_bp[BP_RB]),
    .ex_bus_i(EX_alu_out), .mem_bus_i(Mem_data_mem), .wb_bus_i(WB_data_mem),
    .val_o(b_fwd)
  );

  // Flush overrides hold; a stall only bubbles when EX is free to advance.
  logic load_en, bubble, stall_bubble;
  assign load_en      = flush | ~hold_EX;
  assign stall_bubble = ~flush & ~hold_EX & stall_D;
  assign bubble       = flush | stall_bubble;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [4:0]      rd_q, rd_d;
  logic [OPW-1:0]  alu_op_q, alu_op_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [31:0]     bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    valid_d  = 1'b0;
    pc_d     = '0;
    a_d      = '0;
    b_d      = '0;
    imm_d    = '0;
    rd_d     = '0;
    alu_op_d = '0;
    ctrl_d   = CTRL_BUBBLE;
    if (!bubble) begin
      valid_d  = D_valid;
      pc_d     = D_pc;
      a_d      = a_fwd;
      b_d      = b_fwd;
      imm_d    = D_imm;
      rd_d     = D_rd;
      alu_op_d = D_alu_op;
      ctrl_d   = '{we: D_we & D_valid, ld: D_ld & D_valid,
                   st: D_st & D_valid, br: D_br & D_valid};
    end
    bubble_cnt_d = bubble_cnt_q;
    if (stall_bubble && bubble_cnt_q != 32'hFFFF_FFFF) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      imm_q        <= '0;
      rd_q         <= '0;
      alu_op_q     <= '0;
      ctrl_q       <= CTRL_BUBBLE;
      bubble_cnt_q <= '0;
    end else begin
      if (load_en) begin
        valid_q  <= valid_d;
        pc_q     <= pc_d;
        a_q      <= a_d;
        b_q      <= b_d;
        imm_q    <= imm_d;
        rd_q     <= rd_d;
        alu_op_q <= alu_op_d;
        ctrl_q   <= ctrl_d;
      end
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign EX_valid   = valid_q;
  assign EX_pc      = pc_q;
  assign EX_a       = a_q;
  assign EX_b       = b_q;
  assign EX_imm     = imm_q;
  assign EX_rd      = rd_q;
  assign EX_alu_op  = alu_op_q;
  assign EX_we      = ctrl_q.we;
  assign EX_ld      = ctrl_q.ld;
  assign EX_st      = ctrl_q.st;
  assign EX_br      = ctrl_q.br;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding priority, x0, load-use bubble,
// hold, flush priority, async reset and counter saturation.
module tb_id_ex_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        D_valid;
  logic [31:0] D_pc, D_ra_val, D_rb_val, D_imm;
  logic [4:0]  D_ra, D_rb, D_rd;
  logic [3:0]  D_alu_op;
  logic        D_we, D_ld, D_st, D_br;
  logic        stall_D, flush, hold_EX;
  logic [1:0]  EX_D_bp, MEM_D_bp, WB_D_bp;
  logic [31:0] EX_alu_out, Mem_data_mem, WB_data_mem;
  logic        EX_valid, EX_we, EX_ld, EX_st, EX_br;
  logic [31:0] EX_pc, EX_a, EX_b, EX_imm, bubble_cnt;
  logic [4:0]  EX_rd;
  logic [3:0]  EX_alu_op;

  int n_checks = 0;
  int n_pass   = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .D_valid(D_valid), .D_pc(D_pc),
    .D_ra(D_ra), .D_rb(D_rb), .D_rd(D_rd), .D_ra_val(D_ra_val), .D_rb_val(D_rb_val),
    .D_imm(D_imm), .D_alu_op(D_alu_op), .D_we(D_we), .D_ld(D_ld), .D_st(D_st), .D_br(D_br),
    .stall_D(stall_D), .EX_D_bp(EX_D_bp), .MEM_D_bp(MEM_D_bp), .WB_D_bp(WB_D_bp),
    .EX_alu_out(EX_alu_out), .Mem_data_mem(Mem_data_mem), .WB_data_mem(WB_data_mem),
    .flush(flush), .hold_EX(hold_EX), .EX_valid(EX_valid), .EX_pc(EX_pc), .EX_a(EX_a),
    .EX_b(EX_b), .EX_imm(EX_imm), .EX_rd(EX_rd), .EX_alu_op(EX_alu_op), .EX_we(EX_we),
    .EX_ld(EX_ld), .EX_st(EX_st), .EX_br(EX_br), .bubble_cnt(bubble_cnt)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    D_valid = 0; D_pc = 0; D_ra = 0; D_rb = 0; D_rd = 0; D_ra_val = 0; D_rb_val = 0;
    D_imm = 0; D_alu_op = 0; D_we = 0; D_ld = 0; D_st = 0; D_br = 0;
    stall_D = 0; flush = 0; hold_EX = 0; EX_D_bp = 0; MEM_D_bp = 0; WB_D_bp = 0;
    EX_alu_out = 0; Mem_data_mem = 0; WB_data_mem = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    tick();
    n_checks++; if ({EX_valid, EX_we, EX_ld, EX_st, EX_br} !== 5'b0) $display("FAIL reset_ctrl: got %b want 00000", {EX_valid, EX_we, EX_ld, EX_st, EX_br}); else n_pass++;
    n_checks++; if ({EX_pc, EX_a, EX_b, EX_imm} !== 128'b0) $display("FAIL reset_data: got %h want 0", {EX_pc, EX_a, EX_b, EX_imm}); else n_pass++;
    n_checks++; if (bubble_cnt !== 32'd0) $display("FAIL reset_cnt: got %h want 0", bubble_cnt); else n_pass++;
    rst = 0;
  endtask

  task automatic test_fwd_ex();
    D_valid = 1; D_pc = 32'h100; D_ra = 5; D_rb = 6; D_rd = 7; D_ra_val = 32'h99; D_rb_val = 32'h55;
    D_imm = 32'h1234; D_alu_op = ALU_SUB; D_we = 1;
    EX_D_bp = 2'b10; EX_alu_out = 32'h11;
    tick();
    n_checks++; if (EX_a !== 32'h11) $display("FAIL fwd_ex_a: got %h want 00000011", EX_a); else n_pass++;
    n_checks++; if (EX_b !== 32'h55) $display("FAIL fwd_ex_b: got %h want 00000055", EX_b); else n_pass++;
    n_checks++; if ({EX_valid, EX_we, EX_ld, EX_st, EX_br} !== 5'b11000) $display("FAIL fwd_ex_ctrl: got %b want 11000", {EX_valid, EX_we, EX_ld, EX_st, EX_br}); else n_pass++;
    n_checks++; if ({EX_pc, EX_imm, EX_rd, EX_alu_op} !== {32'h100, 32'h1234, 5'd7, ALU_SUB}) $display("FAIL fwd_ex_fields: got pc=%h imm=%h rd=%0d op=%h want 100/1234/7/1", EX_pc, EX_imm, EX_rd, EX_alu_op); else n_pass++;
  endtask

  task automatic test_priority();
    EX_D_bp = 2'b11; MEM_D_bp = 2'b11; WB_D_bp = 2'b11;
    EX_alu_out = 32'hA; Mem_data_mem = 32'hB; WB_data_mem = 32'hC;
    tick();
    n_checks++; if ({EX_a, EX_b} !== {32'hA, 32'hA}) $display("FAIL prio_ex: got a=%h b=%h want a=A b=A", EX_a, EX_b); else n_pass++;
    EX_D_bp = 2'b00;
    tick();
    n_checks++; if ({EX_a, EX_b} !== {32'hB, 32'hB}) $display("FAIL prio_mem: got a=%h b=%h want a=B b=B", EX_a, EX_b); else n_pass++;
    MEM_D_bp = 2'b01;
    tick();
    n_checks++; if ({EX_a, EX_b} !== {32'hC, 32'hB}) $display("FAIL prio_wb: got a=%h b=%h want a=C b=B", EX_a, EX_b); else n_pass++;
    EX_D_bp = 2'b11; MEM_D_bp = 2'b11; D_ra = 0;
    tick();
    n_checks++; if ({EX_a, EX_b} !== {32'h0, 32'hA}) $display("FAIL x0_ra: got a=%h b=%h want a=0 b=A", EX_a, EX_b); else n_pass++;
    D_ra = 5; D_rb = 0;
    tick();
    n_checks++; if ({EX_a, EX_b} !== {32'hA, 32'h0}) $display("FAIL x0_rb: got a=%h b=%h want a=A b=0", EX_a, EX_b); else n_pass++;
    D_rb = 6; EX_D_bp = 0; MEM_D_bp = 0; WB_D_bp = 0;
    tick();
    n_checks++; if ({EX_a, EX_b} !== {32'h99, 32'h55}) $display("FAIL no_bypass: got a=%h b=%h want a=99 b=55", EX_a, EX_b); else n_pass++;
  endtask

  task automatic test_load_use();
    D_ld = 0; D_we = 1; D_pc = 32'h104;
    stall_D = 1;
    tick();
    n_checks++; if ({EX_valid, EX_we} !== 2'b00) $display("FAIL stall_bubble: got valid/we=%b want 00", {EX_valid, EX_we}); else n_pass++;
    n_checks++; if (bubble_cnt !== 32'd1) $display("FAIL stall_cnt: got %0d want 1", bubble_cnt); else n_pass++;
    stall_D = 0; MEM_D_bp = 2'b10; Mem_data_mem = 32'h77;
    tick();
    n_checks++; if ({EX_valid, EX_a, EX_pc} !== {1'b1, 32'h77, 32'h104}) $display("FAIL load_use_fwd: got valid=%b a=%h pc=%h want 1/77/104", EX_valid, EX_a, EX_pc); else n_pass++;
    n_checks++; if (bubble_cnt !== 32'd1) $display("FAIL load_use_cnt: got %0d want 1", bubble_cnt); else n_pass++;
  endtask

  task automatic test_hold();
    hold_EX = 1;
    for (int i = 0; i < 3; i++) begin
      D_pc = 32'h200 + 32'(i); D_valid = i[0]; stall_D = ~i[0];
      Mem_data_mem = 32'hDEAD0000 + 32'(i); D_ra_val = 32'hBEEF;
      tick();
      n_checks++; if ({EX_valid, EX_we, EX_a, EX_pc} !== {1'b1, 1'b1, 32'h77, 32'h104}) $display("FAIL hold_%0d: got valid=%b we=%b a=%h pc=%h want 1/1/77/104", i, EX_valid, EX_we, EX_a, EX_pc); else n_pass++;
      n_checks++; if (bubble_cnt !== 32'd1) $display("FAIL hold_cnt_%0d: got %0d want 1", i, bubble_cnt); else n_pass++;
    end
  endtask

  task automatic test_flush();
    D_valid = 1; flush = 1; hold_EX = 1; stall_D = 1;
    tick();
    n_checks++; if ({EX_valid, EX_we, EX_ld, EX_st, EX_br, EX_a} !== {5'b0, 32'h0}) $display("FAIL flush_bubble: got ctrl=%b a=%h want 00000/0", {EX_valid, EX_we, EX_ld, EX_st, EX_br}, EX_a); else n_pass++;
    n_checks++; if (bubble_cnt !== 32'd1) $display("FAIL flush_cnt: got %0d want 1", bubble_cnt); else n_pass++;
    flush = 0; hold_EX = 0; stall_D = 0;
    D_valid = 0; D_we = 1; D_ld = 1; D_st = 1; D_br = 1;
    tick();
    n_checks++; if ({EX_valid, EX_we, EX_ld, EX_st, EX_br} !== 5'b0) $display("FAIL invalid_ctrl: got %b want 00000", {EX_valid, EX_we, EX_ld, EX_st, EX_br}); else n_pass++;
    D_valid = 1; D_we = 0; D_ld = 1; D_st = 1; D_br = 1;
    tick();
    n_checks++; if ({EX_valid, EX_we, EX_ld, EX_st, EX_br} !== 5'b10111) $display("FAIL valid_ctrl: got %b want 10111", {EX_valid, EX_we, EX_ld, EX_st, EX_br}); else n_pass++;
  endtask

  task automatic test_saturation();
    force dut.bubble_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.bubble_cnt_q;
    stall_D = 1;
    tick();
    n_checks++; if (bubble_cnt !== 32'hFFFF_FFFF) $display("FAIL sat_1: got %h want ffffffff", bubble_cnt); else n_pass++;
    tick();
    n_checks++; if (bubble_cnt !== 32'hFFFF_FFFF) $display("FAIL sat_2: got %h want ffffffff", bubble_cnt); else n_pass++;
    stall_D = 0;
  endtask

  task automatic test_async_reset();
    D_valid = 1; D_we = 1; D_ld = 0; D_st = 0; D_br = 0; D_pc = 32'h300;
    tick();
    n_checks++; if ({EX_valid, EX_pc} !== {1'b1, 32'h300}) $display("FAIL pre_reset: got valid=%b pc=%h want 1/300", EX_valid, EX_pc); else n_pass++;
    hold_EX = 1; stall_D = 1;
    #2 rst = 1;
    #1;
    n_checks++; if ({EX_valid, EX_we, EX_ld, EX_st, EX_br} !== 5'b0) $display("FAIL async_rst_ctrl: got %b want 00000", {EX_valid, EX_we, EX_ld, EX_st, EX_br}); else n_pass++;
    n_checks++; if ({EX_pc, EX_a, EX_b, EX_imm, EX_rd, EX_alu_op} !== 137'b0) $display("FAIL async_rst_data: got pc=%h a=%h b=%h want 0", EX_pc, EX_a, EX_b); else n_pass++;
    n_checks++; if (bubble_cnt !== 32'd0) $display("FAIL async_rst_cnt: got %h want 0", bubble_cnt); else n_pass++;
    tick();
    rst = 0; hold_EX = 0; stall_D = 0;
    tick();
    n_checks++; if ({EX_valid, EX_pc, bubble_cnt} !== {1'b1, 32'h300, 32'd0}) $display("FAIL post_reset: got valid=%b pc=%h cnt=%0d want 1/300/0", EX_valid, EX_pc, bubble_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fwd_ex();
    test_priority();
    test_load_use();
    test_hold();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
